// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered sequential ALU: opcode set and control state.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        lslOP = 3'd0,
        lsrOP = 3'd1,
        andOP = 3'd2,
        orOP  = 3'd3,
        subOP = 3'd4,
        seqOP = 3'd5,
        sltOP = 3'd6,
        notOP = 3'd7
    } ALU_op_name;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_seq_state_t;

    function automatic logic is_shift(input ALU_op_name op);
        return (op == lslOP) || (op == lsrOP);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Logical shifter: either a combinational barrel shift or a 1-bit-per-step accumulator.
module alu_shifter #(
    parameter int WIDTH      = 8,
    parameter bit FAST_SHIFT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             dir_right,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] amt,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] acc_step;

    always_comb begin
        acc_step = dir_q ? (acc_q >> 1) : (acc_q << 1);
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load) begin
            acc_d = din;
            cnt_d = amt;
            dir_d = dir_right;
        end else if (step && (cnt_q != '0)) begin
            acc_d = acc_step;
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // done marks the step whose edge brings the count to zero; result is the value acc takes then
    always_comb begin
        done = step && (cnt_q == WIDTH'(1));
    end

    generate
        if (FAST_SHIFT) begin : g_barrel
            always_comb begin
                result = dir_right ? (din >> amt) : (din << amt);
            end
        end else begin : g_iter
            always_comb begin
                result = acc_step;
            end
        end
    endgenerate

endmodule

// File: rtl/alu_seq.sv
// Registered ALU behind a valid/ready handshake; iterative shifts hold off in_ready until done.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit FAST_SHIFT = 1'b0,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] srcRS,
    input  logic [WIDTH-1:0] srcRT,
    output logic             out_valid,
    output logic [WIDTH-1:0] destRD,
    output logic             equalFlag,
    output logic             lessThanFlag
);

    localparam logic [WIDTH-1:0] WIDTH_L = WIDTH'(WIDTH);

    alu_seq_state_t   state_q, state_d;
    logic [WIDTH-1:0] dest_q, dest_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             sh_load, sh_step, sh_done;
    logic [WIDTH-1:0] sh_result;
    ALU_op_name       op;

    assign op       = ALU_op_name'(ALUop);
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && (state_q == IDLE);
    assign sh_step  = (state_q == SHIFT);

    alu_shifter #(
        .WIDTH      (WIDTH),
        .FAST_SHIFT (FAST_SHIFT)
    ) u_shifter (
        .clk       (CLK),
        .rst       (reset),
        .load      (sh_load),
        .step      (sh_step),
        .dir_right (op == lsrOP),
        .din       (srcRS),
        .amt       (srcRT),
        .result    (sh_result),
        .done      (sh_done)
    );

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        valid_d = 1'b0;
        sh_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    valid_d = 1'b1;
                    case (op)
                        lslOP, lsrOP: begin
                            // Degenerate amounts finish immediately even in iterative mode
                            if (srcRT == '0) begin
                                dest_d = srcRS;
                            end else if (srcRT >= WIDTH_L) begin
                                dest_d = '0;
                            end else if (FAST_SHIFT) begin
                                dest_d = sh_result;
                            end else begin
                                sh_load = 1'b1;
                                valid_d = 1'b0;
                                state_d = SHIFT;
                            end
                        end
                        andOP: dest_d = srcRS & srcRT;
                        orOP:  dest_d = srcRS | srcRT;
                        subOP: dest_d = srcRS - srcRT;
                        notOP: dest_d = ~srcRS;
                        seqOP: begin
                            dest_d = '0;
                            eq_d   = (srcRS == srcRT);
                        end
                        sltOP: begin
                            dest_d = '0;
                            lt_d   = SIGNED_SLT ? ($signed(srcRS) < $signed(srcRT))
                                                : (srcRS < srcRT);
                        end
                        default: dest_d = dest_q;
                    endcase
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    dest_d  = sh_result;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid    = valid_q;
    assign destRD       = dest_q;
    assign equalFlag    = eq_q;
    assign lessThanFlag = lt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench: iterative/unsigned and barrel/signed instances against an arithmetic model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid_a  [2];
    logic       in_ready_a  [2];
    logic [2:0] op_a        [2];
    logic [7:0] rs_a        [2];
    logic [7:0] rt_a        [2];
    logic       out_valid_a [2];
    logic [7:0] dest_a      [2];
    logic       eq_a        [2];
    logic       lt_a        [2];

    int n_checks = 0;
    int n_errors = 0;
    int dest_m [2];
    int eq_m   [2];
    int lt_m   [2];

    always #5 CLK = ~CLK;

    alu_seq #(.WIDTH(8), .FAST_SHIFT(1'b0), .SIGNED_SLT(1'b0)) dut_iter (
        .CLK(CLK), .reset(reset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .ALUop(op_a[0]), .srcRS(rs_a[0]), .srcRT(rt_a[0]), .out_valid(out_valid_a[0]),
        .destRD(dest_a[0]), .equalFlag(eq_a[0]), .lessThanFlag(lt_a[0])
    );

    alu_seq #(.WIDTH(8), .FAST_SHIFT(1'b1), .SIGNED_SLT(1'b1)) dut_fast (
        .CLK(CLK), .reset(reset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .ALUop(op_a[1]), .srcRS(rs_a[1]), .srcRT(rt_a[1]), .out_valid(out_valid_a[1]),
        .destRD(dest_a[1]), .equalFlag(eq_a[1]), .lessThanFlag(lt_a[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference semantics in plain integer arithmetic on 0..255 values
    function automatic int model_res(input ALU_op_name op, input int a, input int b);
        case (op)
            lslOP:   return (b >= 8) ? 0 : (a * (1 << b)) % 256;
            lsrOP:   return (b >= 8) ? 0 : a / (1 << b);
            andOP:   return a & b;
            orOP:    return a | b;
            subOP:   return (a - b + 256) % 256;
            notOP:   return 255 - a;
            default: return 0;
        endcase
    endfunction

    function automatic void model_apply(input int d, input ALU_op_name op, input int a, input int b);
        dest_m[d] = model_res(op, a, b);
        if (op == seqOP) eq_m[d] = (a == b) ? 1 : 0;
        if (op == sltOP) begin
            if (d == 1) lt_m[d] = (to_signed8(a) < to_signed8(b)) ? 1 : 0;
            else        lt_m[d] = (a < b) ? 1 : 0;
        end
    endfunction

    function automatic int model_latency(input int d, input ALU_op_name op, input int b);
        if (d == 0 && (op == lslOP || op == lsrOP) && b >= 1 && b < 8) return 1 + b;
        return 1;
    endfunction

    task automatic check_outputs(input int d, input string tag);
        check({tag, "_dest"}, 32'(dest_a[d]), 32'(dest_m[d]));
        check({tag, "_eq"},   32'(eq_a[d]),   32'(eq_m[d]));
        check({tag, "_lt"},   32'(lt_a[d]),   32'(lt_m[d]));
    endtask

    // Issue one op from an idle cycle (time = posedge+1) and follow it to its completion pulse
    task automatic do_op(input int d, input ALU_op_name op, input int a, input int b, input string tag);
        int lat;
        int exp_lat;
        check({tag, "_ready"}, 32'(in_ready_a[d]), 32'd1);
        in_valid_a[d] = 1'b1;
        op_a[d] = op;
        rs_a[d] = a[7:0];
        rt_a[d] = b[7:0];
        exp_lat = model_latency(d, op, b);
        model_apply(d, op, a, b);
        @(posedge CLK);
        #1;
        in_valid_a[d] = 1'b0;
        rs_a[d] = 8'($urandom);
        rt_a[d] = 8'($urandom);
        lat = 1;
        while (!out_valid_a[d] && lat < 40) begin
            check({tag, "_busy"}, 32'(in_ready_a[d]), 32'd0);
            @(posedge CLK);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ovalid"}, 32'(out_valid_a[d]), 32'd1);
        check_outputs(d, tag);
        @(posedge CLK);
        #1;
        check({tag, "_pulse"}, 32'(out_valid_a[d]), 32'd0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            dest_m[d] = 0;
            eq_m[d]   = 0;
            lt_m[d]   = 0;
        end
    endtask

    initial begin
        ALU_op_name ops [3];
        int as [3];
        int bs [3];
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d] = 1'b0;
            op_a[d] = 3'd0;
            rs_a[d] = 8'd0;
            rt_a[d] = 8'd0;
        end
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(in_ready_a[d]), 32'd1);
            check("rst_ovalid", 32'(out_valid_a[d]), 32'd0);
            check_outputs(d, "rst");
        end

        do_op(0, lslOP, 8'h81, 3, "lsl_iter3");
        do_op(1, lslOP, 8'h81, 3, "lsl_fast3");
        do_op(0, lsrOP, 8'hF0, 9, "lsr_deg9");
        do_op(0, lsrOP, 8'h5A, 0, "lsr_deg0");
        do_op(0, lsrOP, 8'h80, 7, "lsr_iter7");
        do_op(1, lsrOP, 8'hF0, 8, "lsr_fast8");

        for (int d = 0; d < 2; d++) begin
            do_op(d, seqOP, 8'h3C, 8'h3C, "seq_eq");
            do_op(d, sltOP, 8'h00, 8'h01, "slt_set");
            do_op(d, subOP, 8'h05, 8'h07, "sub_wrap");
            do_op(d, sltOP, 8'h80, 8'h01, "slt_sign");
        end

        // Reset in the middle of an iterative shift: no completion pulse may follow
        in_valid_a[0] = 1'b1;
        op_a[0] = lslOP;
        rs_a[0] = 8'h01;
        rt_a[0] = 8'd5;
        @(posedge CLK);
        #1;
        in_valid_a[0] = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            check("abort_ready", 32'(in_ready_a[d]), 32'd1);
            check_outputs(d, "abort");
        end
        @(posedge CLK);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("abort_noval", 32'(out_valid_a[0]), 32'd0);
            @(posedge CLK);
            #1;
        end
        check_outputs(0, "abort_after");

        // Back-to-back acceptance with in_valid held high
        ops[0] = notOP; as[0] = 8'h0F; bs[0] = 8'h00;
        ops[1] = andOP; as[1] = 8'hF0; bs[1] = 8'h3C;
        ops[2] = orOP;  as[2] = 8'h01; bs[2] = 8'h80;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid_a[d] = 1'b1;
                op_a[d] = ops[i];
                rs_a[d] = as[i][7:0];
                rt_a[d] = bs[i][7:0];
                model_apply(d, ops[i], as[i], bs[i]);
                @(posedge CLK);
                #1;
                check("b2b_ovalid", 32'(out_valid_a[d]), 32'd1);
                check("b2b_ready", 32'(in_ready_a[d]), 32'd1);
                check_outputs(d, "b2b");
            end
            in_valid_a[d] = 1'b0;
            @(posedge CLK);
            #1;
            check("b2b_end", 32'(out_valid_a[d]), 32'd0);
        end

        for (int i = 0; i < 160; i++) begin
            int d;
            int a;
            int b;
            ALU_op_name op;
            d  = i % 2;
            op = ALU_op_name'($urandom_range(0, 7));
            a  = $urandom_range(0, 255);
            if (op == lslOP || op == lsrOP) b = $urandom_range(0, 10);
            else                            b = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0 && op != lslOP && op != lsrOP) b = a;
            do_op(d, op, a, b, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
